// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronise and filter the pins, frame and check
// 11-bit words, fold E0/F0 prefixes into key events and queue them in a FWFT FIFO.
module ps2_key_event_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned FIFO_DEPTH     = 8,
  localparam int unsigned LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps_clk,
  input  logic             ps_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_brk,
  output logic [LVL_W-1:0] fifo_level,
  output logic             frame_err,
  output logic             overflow
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned EVT_W  = 10;
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  logic [1:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic              clk_filt_q;
  logic              clk_prev_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              edge_c;
  logic              bit_c;

  // Two-flop synchronisers, then the clock only moves after FILTER_LEN agreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      fcnt_q     <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps_clk};
      dat_sync_q <= {dat_sync_q[0], ps_data};
      clk_prev_q <= clk_filt_q;
      if (clk_sync_q[1] == clk_filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        fcnt_q     <= '0;
      end else begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
      end
    end
  end

  assign edge_c = clk_prev_q & ~clk_filt_q;
  assign bit_c  = dat_sync_q[1];

  state_t           state_q;
  logic [3:0]       bitcnt_q;
  logic [9:0]       shreg_q;
  logic [TMO_W-1:0] tmo_q;
  logic             ext_pend_q;
  logic             brk_pend_q;
  logic             frame_err_q;
  logic             frame_ok_c;
  logic [7:0]       code_c;
  logic             push_c;

  // shreg_q holds {stop, parity, data[7:0]} once all ten post-start bits are in.
  assign code_c     = shreg_q[7:0];
  assign frame_ok_c = (^shreg_q[8:0]) & shreg_q[9];
  assign push_c     = (state_q == S_CHECK) & frame_ok_c &
                      (code_c != CODE_EXT) & (code_c != CODE_BRK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (edge_c && !bit_c) begin
            state_q  <= S_SHIFT;
            bitcnt_q <= '0;
            tmo_q    <= '0;
          end
        end
        S_SHIFT: begin
          if (edge_c) begin
            shreg_q <= {bit_c, shreg_q[9:1]};
            tmo_q   <= '0;
            if (bitcnt_q == 4'd9) begin
              state_q <= S_CHECK;
            end else begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            frame_err_q <= 1'b1;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_CHECK: begin
          state_q <= S_IDLE;
          if (!frame_ok_c) begin
            frame_err_q <= 1'b1;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
          end else if (code_c == CODE_EXT) begin
            ext_pend_q <= 1'b1;
          end else if (code_c == CODE_BRK) begin
            brk_pend_q <= 1'b1;
          end else begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             evt_valid_q;
  logic             overflow_q;
  logic             pop_c;
  logic             push_ok_c;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_c     = (level_q != '0) & evt_ready;
  assign push_ok_c = push_c & ((level_q < LVL_W'(FIFO_DEPTH)) | pop_c);

  always_comb begin
    level_d = level_q;
    if (push_ok_c && !pop_c) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_ok_c && pop_c) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      evt_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= {brk_pend_q, ext_pend_q, code_c};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !push_ok_c) begin
        overflow_q <= 1'b1;
      end
      level_q     <= level_d;
      evt_valid_q <= (level_d != '0);
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_code   = mem_q[rd_ptr_q][7:0];
  assign evt_ext    = mem_q[rd_ptr_q][8];
  assign evt_brk    = mem_q[rd_ptr_q][9];
  assign fifo_level = level_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
